// File: rtl/crc_stream_engine.sv
// rtl/crc_stream_engine.sv - framed valid/ready CRC engine with configurable width, polynomial and reflection
// Optional CRC_CHECK_EN builds the chk_crc comparator that drives m_err.
module crc_stream_engine #(
    parameter int          DATA_W      = 8,
    parameter int          CRC_W       = 8,
    parameter logic [31:0] POLY        = 32'h07,
    parameter logic [31:0] INIT        = 32'h0,
    parameter logic [31:0] XOR_OUT     = 32'h0,
    parameter bit          REFLECT_IN  = 1'b0,
    parameter bit          REFLECT_OUT = 1'b0,
    parameter int          LEN_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CRC_W-1:0]  m_crc,
    output logic [LEN_W-1:0]  m_len,
    input  logic [CRC_W-1:0]  chk_crc,
    output logic              m_err
);

    localparam logic [CRC_W-1:0] POLY_C = POLY[CRC_W-1:0];
    localparam logic [CRC_W-1:0] INIT_C = INIT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] XOR_C  = XOR_OUT[CRC_W-1:0];

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t             state_q, state_d;
    logic [CRC_W-1:0]   crc_q, crc_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CRC_W-1:0]   out_crc_q, out_crc_d;
    logic [LEN_W-1:0]   out_len_q, out_len_d;
    logic [CRC_W-1:0]   beat_crc;
    logic [CRC_W-1:0]   final_crc;
    logic [LEN_W-1:0]   beat_len;
    logic               accept;

    // All DATA_W serial steps unrolled into one combinational beat update.
    function automatic logic [CRC_W-1:0] crc_beat(input logic [CRC_W-1:0] c,
                                                  input logic [DATA_W-1:0] d);
        logic [CRC_W-1:0] r;
        logic             fb;
        r = c;
        for (int i = 0; i < DATA_W; i++) begin
            fb = r[CRC_W-1] ^ (REFLECT_IN ? d[i] : d[DATA_W-1-i]);
            r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY_C : '0);
        end
        return r;
    endfunction

    function automatic logic [CRC_W-1:0] reverse(input logic [CRC_W-1:0] c);
        logic [CRC_W-1:0] r;
        for (int i = 0; i < CRC_W; i++) begin
            r[i] = c[CRC_W-1-i];
        end
        return r;
    endfunction

    assign m_valid = (state_q == HOLD);
    assign s_ready = !m_valid || m_ready;
    assign accept  = s_valid && s_ready;
    assign m_crc   = out_crc_q;
    assign m_len   = out_len_q;

    // Outside ACC (IDLE, or HOLD being consumed) a beat opens a fresh frame.
    assign beat_crc  = crc_beat((state_q == ACC) ? crc_q : INIT_C, s_data);
    assign final_crc = (REFLECT_OUT ? reverse(beat_crc) : beat_crc) ^ XOR_C;
    assign beat_len  = (state_q != ACC) ? LEN_W'(1)
                     : ((&len_q) ? len_q : len_q + LEN_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            crc_q     <= INIT_C;
            len_q     <= '0;
            out_crc_q <= '0;
            out_len_q <= '0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            len_q     <= len_d;
            out_crc_q <= out_crc_d;
            out_len_q <= out_len_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        len_d     = len_q;
        out_crc_d = out_crc_q;
        out_len_d = out_len_q;
        if (clr) begin
            state_d   = IDLE;
            crc_d     = INIT_C;
            len_d     = '0;
            out_crc_d = '0;
            out_len_d = '0;
        end else if (accept) begin
            if (s_last) begin
                state_d   = HOLD;
                crc_d     = INIT_C;
                len_d     = '0;
                out_crc_d = final_crc;
                out_len_d = beat_len;
            end else begin
                state_d = ACC;
                crc_d   = beat_crc;
                len_d   = beat_len;
            end
        end else if (state_q == HOLD && m_ready) begin
            state_d = IDLE;
            crc_d   = INIT_C;
            len_d   = '0;
        end
    end

`ifdef CRC_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (clr) begin
            err_d = 1'b0;
        end else if (accept && s_last) begin
            err_d = (final_crc != chk_crc);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign m_err = err_q;
`else
    logic unused_chk;
    assign unused_chk = ^chk_crc;
    assign m_err      = 1'b0;
`endif

endmodule

// File: tb/tb_crc_stream_engine.sv
// tb/tb_crc_stream_engine.sv - scoreboard bench: CRC-8 and CRC-16/LEN_W=3 engines on a shared stream
module tb_crc_stream_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic [7:0]  s_data = '0;
    logic        m_ready = 1'b0;
    logic [7:0]  chk0 = '0;
    logic [15:0] chk16 = '0;

    logic        s_ready0, m_valid0, err0;
    logic [7:0]  m_crc0;
    logic [15:0] m_len0;
    logic        s_ready1, m_valid1, err1;
    logic [15:0] m_crc1;
    logic [2:0]  m_len1;

    crc_stream_engine u0 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid0), .m_ready(m_ready), .m_crc(m_crc0), .m_len(m_len0),
        .chk_crc(chk0), .m_err(err0)
    );

    crc_stream_engine #(.CRC_W(16), .POLY(32'h1021), .INIT(32'hFFFF), .LEN_W(3)) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid1), .m_ready(m_ready), .m_crc(m_crc1), .m_len(m_len1),
        .chk_crc(chk16), .m_err(err1)
    );

    always #5 clk = ~clk;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [7:0]  c8;
        logic [15:0] c16;
        int          len;
        logic [7:0]  k8;
        logic [15:0] k16;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ready_mode = 1;
    int   next_id = 0;
    int   first_acc_cyc = -1;
    int   pop_cyc[64];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // CRC of a whole byte message, MSB-first, by the shift/feedback rule.
    function automatic logic [31:0] ref_crc(input bq_t d, input int w,
                                            input logic [31:0] poly, input logic [31:0] init);
        logic [31:0] c, mask;
        logic        fb;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        c = init;
        foreach (d[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[w-1] ^ d[i][b];
                c  = ((c << 1) & mask) ^ (fb ? poly : 32'h0);
            end
        end
        return c;
    endfunction

    task automatic push(input logic [7:0] c8, input logic [15:0] c16, input int len,
                        input logic [7:0] k8, input logic [15:0] k16);
        exp_t e;
        chk0  = k8;
        chk16 = k16;
        e = '{c8, c16, len, k8, k16, next_id};
        exp_q.push_back(e);
        next_id++;
    endtask

    task automatic push_model(input bq_t d);
        logic [7:0]  c8;
        logic [15:0] c16;
        c8  = ref_crc(d, 8, 32'h07, 32'h0);
        c16 = ref_crc(d, 16, 32'h1021, 32'hFFFF);
        push(c8, c16, d.size(), c8 ^ ($urandom_range(0, 1) ? 8'h00 : 8'h5A),
             c16 ^ ($urandom_range(0, 1) ? 16'h0000 : 16'h0101));
    endtask

    task automatic send(input bq_t d, input int gap_pct, input bit close);
        int guard;
        int g;
        bit done;
        for (int i = 0; i < d.size(); i++) begin
            g = 0;
            while (g < 3 && $urandom_range(0, 99) < gap_pct) begin
                @(negedge clk);
                s_valid = 1'b0;
                s_last  = 1'b0;
                g++;
            end
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = d[i];
            s_last  = close && (i == d.size() - 1);
            guard = 0;
            done  = 1'b0;
            while (!done) begin
                #4;
                if (s_ready0) begin
                    if (i == 0) first_acc_cyc = cyc;
                    @(posedge clk);
                    done = 1'b1;
                end else begin
                    guard++;
                    if (guard > 300) begin
                        checks++;
                        errors++;
                        $display("FAIL beat_timeout actual=stalled expected=accepted");
                        s_valid = 1'b0;
                        s_last  = 1'b0;
                        return;
                    end
                    @(negedge clk);
                end
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid0"}, m_valid0, 0);
        check({tag, "_valid1"}, m_valid1, 0);
        check({tag, "_crc0"}, m_crc0, 0);
        check({tag, "_crc1"}, m_crc1, 0);
        check({tag, "_len0"}, m_len0, 0);
        check({tag, "_err0"}, err0, 0);
        check({tag, "_ready0"}, s_ready0, 1);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            case (ready_mode)
                0: m_ready = 1'b0;
                1: m_ready = 1'b1;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: whenever a result is presented, compare against the head of the scoreboard.
    initial begin
        exp_t e;
        logic e0, e1;
        forever begin
            @(negedge clk);
            #4;
            if (rst_n && (m_valid0 || m_valid1)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid actual=%b%b expected=00", m_valid0, m_valid1);
                end else begin
                    e = exp_q[0];
`ifdef CRC_CHECK_EN
                    e0 = (e.c8 != e.k8);
                    e1 = (e.c16 != e.k16);
`else
                    e0 = 1'b0;
                    e1 = 1'b0;
`endif
                    check("m_valid0", m_valid0, 1);
                    check("m_valid1", m_valid1, 1);
                    check("m_crc0", m_crc0, e.c8);
                    check("m_crc1", m_crc1, e.c16);
                    check("m_len0", m_len0, e.len);
                    check("m_len1_sat", m_len1, (e.len > 7) ? 7 : e.len);
                    check("m_err0", err0, e0);
                    check("m_err1", err1, e1);
                    check("s_ready_hold", s_ready0, m_ready);
                    if (m_ready) begin
                        pop_cyc[e.id % 64] = cyc;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        bq_t s9, d;
        int  id_a;
        int  guard;
        s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

        repeat (3) @(negedge clk);
        #4;
        check_reset_state("rst");
        @(negedge clk);
        rst_n = 1'b1;
        ready_mode = 1;
        repeat (2) @(negedge clk);

        push(8'hF4, 16'h29B1, 9, 8'hF4, 16'h29B1);
        send(s9, 0, 1);
        #4;
        check("latency_valid", m_valid0, 1);

        push(8'hF4, 16'h29B1, 9, 8'hF5, 16'h29B0);
        send(s9, 40, 1);
        repeat (3) @(negedge clk);

        // Held result with the next frame waiting: release must consume A and accept B together.
        ready_mode = 0;
        id_a = next_id;
        push(8'hF4, 16'h29B1, 9, 8'hF4, 16'h29B1);
        send(s9, 0, 1);
        repeat (3) @(negedge clk);
        d = {};
        for (int i = 0; i < 5; i++) d.push_back(8'($urandom));
        push_model(d);
        fork
            send(d, 0, 1);
            begin
                repeat (6) @(negedge clk);
                ready_mode = 1;
            end
        join
        check("b2b_same_cycle", first_acc_cyc, pop_cyc[id_a % 64]);
        repeat (3) @(negedge clk);

        d = '{8'h00};
        push(8'h00, 16'(ref_crc(d, 16, 32'h1021, 32'hFFFF)), 1, 8'h00, 16'h0);
        send(d, 0, 1);
        d = '{8'h01};
        push(8'h07, 16'(ref_crc(d, 16, 32'h1021, 32'hFFFF)), 1, 8'h07, 16'h0);
        send(d, 0, 1);
        repeat (3) @(negedge clk);

        d = '{8'hAA, 8'h55, 8'h12, 8'h34};
        send(d, 0, 0);
        @(negedge clk);
        clr = 1'b1;
        s_valid = 1'b1;
        s_data = 8'h99;
        s_last = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        s_valid = 1'b0;
        s_last = 1'b0;
        #4;
        check("clr_no_valid", m_valid0, 0);
        repeat (3) @(negedge clk);
        push(8'hF4, 16'h29B1, 9, 8'hF4, 16'h29B1);
        send(s9, 0, 1);
        repeat (3) @(negedge clk);

        send(d, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_state("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        push(8'hF4, 16'h29B1, 9, 8'hF4, 16'h29B1);
        send(s9, 0, 1);
        repeat (3) @(negedge clk);

        ready_mode = 2;
        for (int f = 0; f < 25; f++) begin
            d = {};
            for (int i = 0; i < $urandom_range(1, 12); i++) d.push_back(8'($urandom));
            push_model(d);
            send(d, 30, 1);
        end

        ready_mode = 1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("drain_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc_stream_engine.md
Name: crc_stream_engine

Overview:
- Parametrised successor to the fixed 8-bit CRC-8 datapath.
- Computes a CRC over a framed, valid/ready data stream of configurable beat width, with configurable polynomial, init value, reflection and final XOR.
- Presents one result per frame on a held output handshake, together with the frame beat count.
- Sits between the frame parser and the response/validation logic of the slave interface.

Parameters:
- DATA_W, 8: beat width in bits, 1..64.
- CRC_W, 8: CRC width in bits, 3..32.
- POLY, 'h07: generator polynomial without the x^CRC_W term. The default is 1+x+x^2+x^8.
- INIT, 0: register value loaded at the start of each frame.
- XOR_OUT, 0: value XORed onto the final CRC.
- REFLECT_IN, 0: when 1, each beat is processed LSB-first; when 0, MSB-first.
- REFLECT_OUT, 0: when 1, the final CRC is bit-reversed before XOR_OUT is applied.
- LEN_W, 16: width of the beat counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous abort: drops the frame in progress and any held result.
- s_valid  in  1  input beat valid.
- s_ready  out  1  engine can accept a beat.
- s_data  in  DATA_W  input beat.
- s_last  in  1  marks the final beat of a frame.
- m_valid  out  1  result valid.
- m_ready  in  1  result consumed.
- m_crc  out  CRC_W  final CRC, after reflection and XOR_OUT.
- m_len  out  LEN_W  number of beats in the frame, saturating.
- chk_crc  in  CRC_W  expected CRC, sampled on the s_last beat (CRC_CHECK_EN only).
- m_err  out  1  CRC mismatch flag (CRC_CHECK_EN only; otherwise tied 0).

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, crc_q=INIT, len_q=0, m_valid=0, m_crc=0, m_len=0, m_err=0.
- Beat accepted when s_valid & s_ready.
- s_ready = !m_valid | m_ready. This allows the first beat of the next frame in the same cycle the result is consumed.
- Per-beat update: DATA_W serial steps evaluated combinationally in one cycle.
  - Each step: fb = crc[CRC_W-1] ^ d_bit; crc = (crc<<1) ^ (fb ? POLY : 0).
  - Bit order follows REFLECT_IN.
  - Result registered, giving 1 beat per clock and no internal bubbles.
- States:
  - IDLE: no frame open. An accepted beat computes from INIT (ignoring crc_q), sets len_q=1, and moves to ACC. If s_last is also set, it goes straight to HOLD.
  - ACC: an accepted beat computes from crc_q and sets len_q=len_q+1, saturating at all-ones. On s_last, go to HOLD.
  - HOLD: m_valid=1. m_crc, m_len and m_err are stable until m_ready.
    - m_ready & accepted beat: behave as IDLE for that beat.
    - m_ready & no beat: go to IDLE.
- Result timing: m_valid rises on the cycle after the s_last beat is accepted, i.e. 1-cycle latency.
- crc_q reloads INIT when entering IDLE.
- m_crc = (REFLECT_OUT ? reverse(crc_final) : crc_final) ^ XOR_OUT, registered at the s_last beat.
- A single-beat frame (s_last on the first beat) is legal: m_len=1.
- clr has priority over all other inputs. It forces IDLE, drops m_valid, and reloads INIT and len_q=0. A beat presented in the same cycle as clr is discarded.
- rst_n asserted mid-frame: immediate return to reset values. A partial frame never produces a result.
- m_ready while m_valid=0: ignored.
- s_valid is never required to be continuous; idle cycles inside a frame hold crc_q and len_q.

Optional Feature:
- Macro: CRC_CHECK_EN.
- Defined: chk_crc is sampled on the s_last beat. m_err = (m_crc != chk_crc), registered with m_crc and valid only while m_valid=1.
- Not defined: the comparator and the chk_crc sampling register are not built. chk_crc is unused and m_err is constant 0.

Test Plan:
- Defaults; ASCII "123456789" as 9 back-to-back beats, s_last on '9', m_ready=1 -> one cycle later m_valid=1, m_crc=8'hF4, m_len=9.
- CRC_W=16, POLY='h1021, INIT='hFFFF, DATA_W=8; same string -> m_crc=16'h29B1. Repeat with random s_valid gaps -> identical result.
- Hold m_ready=0 after frame A, then present frame B -> s_ready=0, A's m_crc/m_len stable. Release m_ready with B's first beat valid -> A is consumed and B's beat is accepted from INIT in that same cycle.
- Single beat 8'h00 with s_last, defaults -> m_crc=8'h00, m_len=1. Single beat 8'h01 -> m_crc=8'h07.
- Mid-frame: 4 beats, then clr=1 with s_valid=1 -> no m_valid. The next frame "123456789" gives 8'hF4. Repeat using rst_n low for 1 cycle instead of clr -> same.
- CRC_CHECK_EN: chk_crc=8'hF4 on "123456789" -> m_err=0. chk_crc=8'hF5 -> m_err=1. Without the macro -> m_err=0 in both cases.
